// File: rtl/PECfg.sv
// Shared PE configuration: partial-sum width and the psum collector state type.
package PECfg;

  localparam int DWd = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    FLUSH   = 2'd2
  } PsumColState_t;

endpackage

// File: rtl/psum_fifo.sv
// Synchronous FIFO with power-of-2 depth, wrapping pointers and an occupancy count.
module psum_fifo #(
  parameter int W     = 17,
  parameter int Depth = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           wdata,
  output logic [W-1:0]           rdata,
  output logic [$clog2(Depth):0] count,
  output logic                   empty,
  output logic                   full
);

  localparam int AW = $clog2(Depth);

  logic [W-1:0]  mem [Depth];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(Depth));
  assign do_pop  = pop && !empty;
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  // Pointers wrap naturally because Depth is a power of 2.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  // NOTE: storage is not reset; entries are only visible through count, so
  // leaving the array out of reset keeps it a plain RAM without a clear path.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/psum_collector.sv
// Collects one output row of PE partial sums into a small FIFO and streams it
// downstream with a last tag, requesting a stall before the FIFO overflows.
module psum_collector #(
  parameter int DWd   = PECfg::DWd,
  parameter int Depth = 4,
  parameter int CntWd = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  input  logic [CntWd-1:0]      i_row_len,
  input  logic                  i_psum_valid,
  input  logic signed [DWd-1:0] i_psum,
  output logic                  o_stall_req,
  output logic                  o_dval,
  input  logic                  i_drdy,
  output logic signed [DWd-1:0] o_data,
  output logic                  o_last,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_ovf
);

  import PECfg::*;

  localparam int CW = $clog2(Depth) + 1;

  PsumColState_t    state;
  PsumColState_t    state_next;
  logic [CntWd-1:0] remaining;
  logic [CntWd-1:0] remaining_next;
  logic             ovf_q;
  logic             drop;
  logic             row_done;
  logic             push;
  logic             pop;
  logic             fifo_empty;
  logic             fifo_full;
  logic [CW-1:0]    fifo_count;
  logic [DWd:0]     fifo_wdata;
  logic [DWd:0]     fifo_rdata;

  psum_fifo #(
    .W     (DWd + 1),
    .Depth (Depth)
  ) u_fifo (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .push  (push),
    .pop   (pop),
    .wdata (fifo_wdata),
    .rdata (fifo_rdata),
    .count (fifo_count),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  assign pop        = o_dval && i_drdy;
  assign fifo_wdata = {remaining == CntWd'(1), i_psum};

  // NOTE: every output of this block gets a default first, so no path leaves
  // a variable unassigned and no latch is inferred.
  always_comb begin
    state_next     = state;
    remaining_next = remaining;
    push           = 1'b0;
    drop           = 1'b0;
    row_done       = 1'b0;
    case (state)
      IDLE: begin
        if (i_start) begin
          remaining_next = i_row_len;
          state_next     = (i_row_len == '0) ? FLUSH : COLLECT;
        end
      end
      COLLECT: begin
        if (i_psum_valid) begin
          if (!fifo_full || pop) begin
            push           = 1'b1;
            remaining_next = remaining - CntWd'(1);
            if (remaining == CntWd'(1)) state_next = FLUSH;
          end else begin
            drop = 1'b1;
          end
        end
      end
      FLUSH: begin
        if (fifo_empty) begin
          row_done   = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the values from before the edge, independent of statement order.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state     <= IDLE;
      remaining <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state     <= state_next;
      remaining <= remaining_next;
      ovf_q     <= ovf_q | drop;
    end
  end

  // Outputs are gated by reset so they read zero even before the first edge.
  assign o_dval      = i_rst_n && !fifo_empty;
  assign o_data      = o_dval ? fifo_rdata[DWd-1:0] : '0;
  assign o_last      = o_dval && fifo_rdata[DWd];
  assign o_busy      = i_rst_n && (state != IDLE);
  assign o_done      = i_rst_n && row_done;
  assign o_ovf       = i_rst_n && ovf_q;
  assign o_stall_req = i_rst_n && (state == COLLECT) &&
                       (fifo_count >= CW'(Depth - 1));

endmodule

// File: tb/tb_psum_collector.sv
// Self-checking bench for psum_collector: directed row scenarios plus a
// randomized run compared against a queue-based behavioural model.
module tb_psum_collector;

  localparam int DWd   = PECfg::DWd;
  localparam int Depth = 4;
  localparam int CntWd = 8;

  logic                  i_clk;
  logic                  i_rst_n;
  logic                  i_start;
  logic [CntWd-1:0]      i_row_len;
  logic                  i_psum_valid;
  logic signed [DWd-1:0] i_psum;
  logic                  o_stall_req;
  logic                  o_dval;
  logic                  i_drdy;
  logic signed [DWd-1:0] o_data;
  logic                  o_last;
  logic                  o_busy;
  logic                  o_done;
  logic                  o_ovf;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  // Observed bundle: {busy, done, dval, last, stall, ovf, data}
  logic [DWd+5:0] obs;
  logic [DWd+5:0] exp_v;
  assign obs = {o_busy, o_done, o_dval, o_last, o_stall_req, o_ovf, o_data};

  psum_collector #(
    .DWd   (DWd),
    .Depth (Depth),
    .CntWd (CntWd)
  ) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_start      (i_start),
    .i_row_len    (i_row_len),
    .i_psum_valid (i_psum_valid),
    .i_psum       (i_psum),
    .o_stall_req  (o_stall_req),
    .o_dval       (o_dval),
    .i_drdy       (i_drdy),
    .o_data       (o_data),
    .o_last       (o_last),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_ovf        (o_ovf)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  function automatic logic [DWd+5:0] pk(input int b, input int dn, input int v,
                                        input int l, input int s, input int o,
                                        input int d);
    logic [DWd-1:0] dd;
    dd = DWd'(d);
    return {b[0], dn[0], v[0], l[0], s[0], o[0], dd};
  endfunction

  // Advance one cycle; outputs are sampled 1 time unit after the edge.
  task automatic tick;
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle_inputs;
    i_start      = 1'b0;
    i_row_len    = '0;
    i_psum_valid = 1'b0;
    i_psum       = '0;
    i_drdy       = 1'b0;
  endtask

  task automatic do_reset;
    idle_inputs();
    i_rst_n = 1'b0;
    tick();
    tick();
    i_rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset;
    idle_inputs();
    i_rst_n = 1'b0;
    #1;
    exp_v = pk(0,0,0,0,0,0,0); chk_cnt++; if (obs !== exp_v) $display("FAIL reset_pre got=%h exp=%h", obs, exp_v); else pass_cnt++;
    tick();
    exp_v = pk(0,0,0,0,0,0,0); chk_cnt++; if (obs !== exp_v) $display("FAIL reset_during got=%h exp=%h", obs, exp_v); else pass_cnt++;
    i_start = 1'b1; i_row_len = 8'd3; i_psum_valid = 1'b1; i_psum = 16'sd9; i_drdy = 1'b1;
    tick();
    exp_v = pk(0,0,0,0,0,0,0); chk_cnt++; if (obs !== exp_v) $display("FAIL reset_hold got=%h exp=%h", obs, exp_v); else pass_cnt++;
    idle_inputs();
    i_rst_n = 1'b1;
    tick();
    exp_v = pk(0,0,0,0,0,0,0); chk_cnt++; if (obs !== exp_v) $display("FAIL reset_after got=%h exp=%h", obs, exp_v); else pass_cnt++;
  endtask

  task automatic test_basic_row;
    do_reset();
    i_drdy = 1'b1;
    i_start = 1'b1; i_row_len = 8'd3;
    tick();
    i_start = 1'b0;
    exp_v = pk(1,0,0,0,0,0,0); chk_cnt++; if (obs !== exp_v) $display("FAIL basic_start got=%h exp=%h", obs, exp_v); else pass_cnt++;
    i_psum_valid = 1'b1; i_psum = 16'sd5;
    tick();
    exp_v = pk(1,0,1,0,0,0,5); chk_cnt++; if (obs !== exp_v) $display("FAIL basic_p0 got=%h exp=%h", obs, exp_v); else pass_cnt++;
    i_psum = -16'sd2;
    tick();
    exp_v = pk(1,0,1,0,0,0,-2); chk_cnt++; if (obs !== exp_v) $display("FAIL basic_p1 got=%h exp=%h", obs, exp_v); else pass_cnt++;
    i_psum = 16'sd7;
    tick();
    i_psum_valid = 1'b0;
    exp_v = pk(1,0,1,1,0,0,7); chk_cnt++; if (obs !== exp_v) $display("FAIL basic_p2_last got=%h exp=%h", obs, exp_v); else pass_cnt++;
    tick();
    exp_v = pk(1,1,0,0,0,0,0); chk_cnt++; if (obs !== exp_v) $display("FAIL basic_done got=%h exp=%h", obs, exp_v); else pass_cnt++;
    tick();
    exp_v = pk(0,0,0,0,0,0,0); chk_cnt++; if (obs !== exp_v) $display("FAIL basic_idle got=%h exp=%h", obs, exp_v); else pass_cnt++;
  endtask

  task automatic test_overflow;
    do_reset();
    i_start = 1'b1; i_row_len = 8'd6;
    tick();
    i_start = 1'b0;
    i_psum_valid = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      i_psum = DWd'(k * 10);
      tick();
      exp_v = pk(1,0,1,0,(k >= 3),0,10); chk_cnt++; if (obs !== exp_v) $display("FAIL ovf_fill%0d got=%h exp=%h", k, obs, exp_v); else pass_cnt++;
    end
    i_psum = 16'sd99;
    tick();
    exp_v = pk(1,0,1,0,1,1,10); chk_cnt++; if (obs !== exp_v) $display("FAIL ovf_drop got=%h exp=%h", obs, exp_v); else pass_cnt++;
    i_psum_valid = 1'b0;
    i_drdy = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      exp_v = pk(1,0,1,0,(i == 1),1,(i + 1) * 10); chk_cnt++; if (obs !== exp_v) $display("FAIL ovf_drain%0d got=%h exp=%h", i, obs, exp_v); else pass_cnt++;
    end
    tick();
    exp_v = pk(1,0,0,0,0,1,0); chk_cnt++; if (obs !== exp_v) $display("FAIL ovf_empty got=%h exp=%h", obs, exp_v); else pass_cnt++;
    i_psum_valid = 1'b1; i_psum = 16'sd1;
    tick();
    exp_v = pk(1,0,1,0,0,1,1); chk_cnt++; if (obs !== exp_v) $display("FAIL ovf_rest0 got=%h exp=%h", obs, exp_v); else pass_cnt++;
    i_psum = 16'sd2;
    tick();
    i_psum_valid = 1'b0;
    exp_v = pk(1,0,1,1,0,1,2); chk_cnt++; if (obs !== exp_v) $display("FAIL ovf_rest1 got=%h exp=%h", obs, exp_v); else pass_cnt++;
    tick();
    exp_v = pk(1,1,0,0,0,1,0); chk_cnt++; if (obs !== exp_v) $display("FAIL ovf_done got=%h exp=%h", obs, exp_v); else pass_cnt++;
    tick();
    exp_v = pk(0,0,0,0,0,1,0); chk_cnt++; if (obs !== exp_v) $display("FAIL ovf_sticky got=%h exp=%h", obs, exp_v); else pass_cnt++;
  endtask

  task automatic test_full_push_pop;
    do_reset();
    i_start = 1'b1; i_row_len = 8'd6;
    tick();
    i_start = 1'b0;
    i_psum_valid = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      i_psum = DWd'(k);
      tick();
    end
    exp_v = pk(1,0,1,0,1,0,1); chk_cnt++; if (obs !== exp_v) $display("FAIL fpp_full got=%h exp=%h", obs, exp_v); else pass_cnt++;
    i_psum = 16'sd5; i_drdy = 1'b1;
    tick();
    exp_v = pk(1,0,1,0,1,0,2); chk_cnt++; if (obs !== exp_v) $display("FAIL fpp_pushpop got=%h exp=%h", obs, exp_v); else pass_cnt++;
    i_psum_valid = 1'b0; i_drdy = 1'b0;
    tick();
    exp_v = pk(1,0,1,0,1,0,2); chk_cnt++; if (obs !== exp_v) $display("FAIL fpp_hold got=%h exp=%h", obs, exp_v); else pass_cnt++;
    i_drdy = 1'b1;
    for (int v = 3; v <= 5; v++) begin
      tick();
      exp_v = pk(1,0,1,0,(v == 3),0,v); chk_cnt++; if (obs !== exp_v) $display("FAIL fpp_drain%0d got=%h exp=%h", v, obs, exp_v); else pass_cnt++;
    end
    tick();
    exp_v = pk(1,0,0,0,0,0,0); chk_cnt++; if (obs !== exp_v) $display("FAIL fpp_count4 got=%h exp=%h", obs, exp_v); else pass_cnt++;
    i_psum_valid = 1'b1; i_psum = 16'sd6;
    tick();
    i_psum_valid = 1'b0;
    exp_v = pk(1,0,1,1,0,0,6); chk_cnt++; if (obs !== exp_v) $display("FAIL fpp_last got=%h exp=%h", obs, exp_v); else pass_cnt++;
    tick();
    exp_v = pk(1,1,0,0,0,0,0); chk_cnt++; if (obs !== exp_v) $display("FAIL fpp_done got=%h exp=%h", obs, exp_v); else pass_cnt++;
  endtask

  task automatic test_zero_len;
    do_reset();
    i_start = 1'b1; i_row_len = 8'd0;
    tick();
    i_start = 1'b0;
    exp_v = pk(1,1,0,0,0,0,0); chk_cnt++; if (obs !== exp_v) $display("FAIL zero_flush got=%h exp=%h", obs, exp_v); else pass_cnt++;
    tick();
    exp_v = pk(0,0,0,0,0,0,0); chk_cnt++; if (obs !== exp_v) $display("FAIL zero_idle got=%h exp=%h", obs, exp_v); else pass_cnt++;
  endtask

  task automatic test_reset_mid_row;
    do_reset();
    i_start = 1'b1; i_row_len = 8'd4;
    tick();
    i_start = 1'b0;
    i_psum_valid = 1'b1; i_psum = 16'sd21;
    tick();
    i_psum = 16'sd22;
    tick();
    i_psum_valid = 1'b0;
    exp_v = pk(1,0,1,0,0,0,21); chk_cnt++; if (obs !== exp_v) $display("FAIL rmid_pre got=%h exp=%h", obs, exp_v); else pass_cnt++;
    i_rst_n = 1'b0;
    tick();
    exp_v = pk(0,0,0,0,0,0,0); chk_cnt++; if (obs !== exp_v) $display("FAIL rmid_cleared got=%h exp=%h", obs, exp_v); else pass_cnt++;
    i_rst_n = 1'b1;
    tick();
    exp_v = pk(0,0,0,0,0,0,0); chk_cnt++; if (obs !== exp_v) $display("FAIL rmid_nodone got=%h exp=%h", obs, exp_v); else pass_cnt++;
    i_drdy = 1'b1;
    i_start = 1'b1; i_row_len = 8'd2;
    tick();
    i_start = 1'b0;
    i_psum_valid = 1'b1; i_psum = 16'sd31;
    tick();
    exp_v = pk(1,0,1,0,0,0,31); chk_cnt++; if (obs !== exp_v) $display("FAIL rmid_new0 got=%h exp=%h", obs, exp_v); else pass_cnt++;
    i_psum = 16'sd32;
    tick();
    i_psum_valid = 1'b0;
    exp_v = pk(1,0,1,1,0,0,32); chk_cnt++; if (obs !== exp_v) $display("FAIL rmid_new1 got=%h exp=%h", obs, exp_v); else pass_cnt++;
    tick();
    exp_v = pk(1,1,0,0,0,0,0); chk_cnt++; if (obs !== exp_v) $display("FAIL rmid_done got=%h exp=%h", obs, exp_v); else pass_cnt++;
  endtask

  task automatic test_start_ignored;
    do_reset();
    i_drdy = 1'b1;
    i_start = 1'b1; i_row_len = 8'd3;
    tick();
    i_start = 1'b0;
    i_psum_valid = 1'b1; i_psum = 16'sd41;
    tick();
    exp_v = pk(1,0,1,0,0,0,41); chk_cnt++; if (obs !== exp_v) $display("FAIL ign_p0 got=%h exp=%h", obs, exp_v); else pass_cnt++;
    i_start = 1'b1; i_row_len = 8'd1; i_psum = 16'sd42;
    tick();
    i_start = 1'b0;
    exp_v = pk(1,0,1,0,0,0,42); chk_cnt++; if (obs !== exp_v) $display("FAIL ign_p1 got=%h exp=%h", obs, exp_v); else pass_cnt++;
    i_psum = 16'sd43;
    tick();
    i_psum_valid = 1'b0;
    exp_v = pk(1,0,1,1,0,0,43); chk_cnt++; if (obs !== exp_v) $display("FAIL ign_p2_last got=%h exp=%h", obs, exp_v); else pass_cnt++;
    tick();
    exp_v = pk(1,1,0,0,0,0,0); chk_cnt++; if (obs !== exp_v) $display("FAIL ign_done got=%h exp=%h", obs, exp_v); else pass_cnt++;
  endtask

  typedef struct {
    logic                  last;
    logic signed [DWd-1:0] data;
  } ent_t;

  // Reference: a row is idle (0), collecting (1) or flushing (2); the FIFO is
  // a queue of accepted psums, each tagged when it completes the row.
  task automatic test_random;
    ent_t q[$];
    ent_t e;
    int   phase = 0;
    int   rem   = 0;
    int   ovf   = 0;
    int   sz;
    bit   pop_m;
    bit   push_m;
    do_reset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      sz = q.size();
      exp_v = pk((phase != 0), (phase == 2 && sz == 0), (sz > 0),
                 (sz > 0) ? int'(q[0].last) : 0,
                 (phase == 1 && sz >= Depth - 1), ovf,
                 (sz > 0) ? int'(q[0].data) : 0);
      chk_cnt++; if (obs !== exp_v) $display("FAIL rand_cyc%0d got=%h exp=%h", cyc, obs, exp_v); else pass_cnt++;

      i_start      = ($urandom_range(0, 3) == 0);
      i_row_len    = CntWd'($urandom_range(0, 7));
      i_psum_valid = $urandom_range(0, 1) == 1;
      i_psum       = DWd'($urandom);
      i_drdy       = ($urandom_range(0, 9) < 6);

      pop_m  = (sz > 0) && i_drdy;
      push_m = 1'b0;
      if (phase == 0) begin
        if (i_start) begin
          rem   = int'(i_row_len);
          phase = (rem == 0) ? 2 : 1;
        end
      end else if (phase == 1) begin
        if (i_psum_valid) begin
          if (sz < Depth || pop_m) begin
            push_m = 1'b1;
            e.last = (rem == 1);
            e.data = i_psum;
            rem    = rem - 1;
            if (rem == 0) phase = 2;
          end else begin
            ovf = 1;
          end
        end
      end else if (sz == 0) begin
        phase = 0;
      end
      if (pop_m)  void'(q.pop_front());
      if (push_m) q.push_back(e);
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_basic_row();
    test_overflow();
    test_full_push_pop();
    test_zero_len();
    test_reset_mid_row();
    test_start_ignored();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
